alarm_timekeeper: RTL
=====================

Name: alarm_timekeeper

Overview:
- Parametrised successor to the single-alarm mm:ss clock. Keeps 24-hour BCD time (hh:mm:ss) from a prescaled system clock.
- Holds NUM_ALARMS independently programmable alarm channels, each with its own ring/snooze/timeout state machine.
- Sits between the board switches/buttons and the display multiplexer and song player. It feeds time_bcd to the display path and ring_any to the audio enable.

Parameters:
- CLK_HZ, 100_000_000, system clock cycles per second; the prescaler wraps at CLK_HZ-1.
- NUM_ALARMS, 4, number of alarm channels (1..8).
- SNOOZE_S, 300, snooze length in seconds (1..65535).
- RING_TIMEOUT_S, 60, seconds an unattended alarm rings before auto-stop (1..65535).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- set_time_valid  in  1  one-cycle strobe: load set_time.
- set_time  in  24  BCD {h10,h1,m10,m1,s10,s1}, 4 bits per digit.
- alarm_wr  in  1  one-cycle strobe: write alarm_time into slot alarm_idx.
- alarm_idx  in  3  target slot; writes with alarm_idx >= NUM_ALARMS are ignored.
- alarm_time  in  24  BCD alarm time, same format as set_time.
- alarm_en  in  NUM_ALARMS  level enable per channel.
- snooze  in  1  one-cycle strobe (debounced upstream).
- dismiss  in  1  one-cycle strobe.
- time_bcd  out  24  current time.
- sec_tick  out  1  one-cycle pulse on every second increment.
- ring  out  NUM_ALARMS  per-channel ringing.
- ring_any  out  1  OR of ring.
- snoozed  out  NUM_ALARMS  per-channel snooze active.
- set_err  out  1  one-cycle pulse: invalid BCD on a set_time or alarm write.

Behaviour:
- Reset (rst_n low, asynchronous): time_bcd=00:00:00, prescaler=0, sec_tick=0, all alarm slots=00:00:00, all channels IDLE, ring=0, ring_any=0, snoozed=0, set_err=0.
- Prescaler: counts 0..CLK_HZ-1. On the edge where it holds CLK_HZ-1 it wraps to 0, time_bcd increments and sec_tick=1 for that single cycle.
- Increment: s1 wraps 9->0 with carry; s10 wraps 5->0; m1/m10 likewise; hours wrap 23->00; 23:59:59 -> 00:00:00.
- Time load: set_time_valid with a valid value (h<=23, m10<=5, s10<=5, every digit <=9) loads time_bcd on the next edge and clears the prescaler. A load does not assert sec_tick and never triggers an alarm match.
- Invalid time load or alarm write: the value is discarded and set_err pulses one cycle.
- Load vs tick: set_time_valid takes priority over a coincident tick; that tick is dropped.
- Alarm write: writing a slot forces that channel to IDLE (ring/snooze cleared) on the same edge.
- Channel FSM, states IDLE, RINGING, SNOOZED, each with a 16-bit seconds counter:
  - IDLE -> RINGING: alarm_en[i]=1, sec_tick=1 and the new time_bcd equals slot i. ring[i] rises one cycle after time_bcd shows the match value.
  - RINGING -> SNOOZED on snooze; counter loaded with SNOOZE_S.
  - RINGING -> IDLE on dismiss, or when RING_TIMEOUT_S sec_ticks have elapsed since entry.
  - SNOOZED -> RINGING when the counter reaches 0 after SNOOZE_S sec_ticks; the timeout counter restarts.
  - SNOOZED -> IDLE on dismiss.
  - Any state -> IDLE within one cycle when alarm_en[i] drops.
- Broadcast: snooze and dismiss act on all channels simultaneously. If both strobe in the same cycle, dismiss wins.
- Re-match: a match while already RINGING or SNOOZED is ignored.
- Simultaneous matches: several channels matching the same second all ring.
- Outputs: ring[i]=(state==RINGING); snoozed[i]=(state==SNOOZED). All outputs are registered.

Decomposition:
- Shared package alarm_pkg holds:
  - bcd_time_t (24-bit struct of six 4-bit digits);
  - digit limit constants;
  - chan_state_t enum {IDLE, RINGING, SNOOZED};
  - function bcd_time_valid().
- Sub-module alarm_channel, instantiated NUM_ALARMS times via generate. It contains the slot register, the comparator, the FSM and the seconds counter.
- The top level holds the prescaler, the time counter, write decode and validity checks.

Test Plan:
- Rollover: CLK_HZ=10, load 23:59:58, wait 20 clk -> time_bcd 23:59:59, then 00:00:00; exactly two sec_tick pulses.
- Match latency: slot0=00:00:05, en=0001, load 00:00:03 -> ring[0] rises one clk after time_bcd=00:00:05; ring_any=1; ring[3:1]=0.
- Snooze/timeout: SNOOZE_S=3, RING_TIMEOUT_S=4, ringing, snooze -> snoozed[0]=1 for 3 ticks, re-rings; no action -> ring[0] drops after 4 ticks.
- Dismiss priority: snooze and dismiss in the same clk while ch0 and ch2 ring -> ring=0000, snoozed=0000.
- Invalid input: set_time=24:00:00 or alarm_time s10=6 -> set_err one clk pulse, time_bcd/slot unchanged; alarm_idx=5 with NUM_ALARMS=4 -> no change.
- Async reset mid-ring: drop rst_n between edges -> ring, snoozed, time_bcd clear immediately, before the next clk edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the 24-hour BCD alarm clock: time struct,
// digit limits, channel state encoding, validity check and BCD increment.
package alarm_pkg;

    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h1;
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } bcd_time_t;

    localparam logic [3:0] DIG_MAX    = 4'd9;
    localparam logic [3:0] TENS_MAX   = 4'd5;
    localparam logic [3:0] H10_MAX    = 4'd2;
    localparam logic [3:0] H1_MAX_24  = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZED
    } chan_state_t;

    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic hours_ok;
        hours_ok = (t.h10 < H10_MAX && t.h1 <= DIG_MAX) ||
                   (t.h10 == H10_MAX && t.h1 <= H1_MAX_24);
        return hours_ok && (t.m10 <= TENS_MAX) && (t.m1 <= DIG_MAX) &&
               (t.s10 <= TENS_MAX) && (t.s1 <= DIG_MAX);
    endfunction

    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s1 != DIG_MAX) begin
            r.s1 = t.s1 + 4'd1;
        end else begin
            r.s1 = '0;
            if (t.s10 != TENS_MAX) begin
                r.s10 = t.s10 + 4'd1;
            end else begin
                r.s10 = '0;
                if (t.m1 != DIG_MAX) begin
                    r.m1 = t.m1 + 4'd1;
                end else begin
                    r.m1 = '0;
                    if (t.m10 != TENS_MAX) begin
                        r.m10 = t.m10 + 4'd1;
                    end else begin
                        r.m10 = '0;
                        if (t.h10 == H10_MAX && t.h1 == H1_MAX_24) begin
                            r.h10 = '0;
                            r.h1  = '0;
                        end else if (t.h1 == DIG_MAX) begin
                            r.h1  = '0;
                            r.h10 = t.h10 + 4'd1;
                        end else begin
                            r.h1 = t.h1 + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: slot register, match comparator and the
// idle/ringing/snoozed state machine with its seconds counter.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned RING_TIMEOUT_S = 60
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr,
    input  bcd_time_t wr_time,
    input  logic      en,
    input  logic      sec_tick,
    input  bcd_time_t now,
    input  logic      snooze,
    input  logic      dismiss,
    output logic      ring,
    output logic      snoozed,
    output logic      ring_next
);

    localparam logic [15:0] SNOOZE_CNT = 16'(SNOOZE_S);
    localparam logic [15:0] RING_CNT   = 16'(RING_TIMEOUT_S);

    chan_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    bcd_time_t   slot_q, slot_d;
    logic        ring_q, ring_d;
    logic        snoozed_q, snoozed_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            ring_q    <= 1'b0;
            snoozed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            ring_q    <= ring_d;
            snoozed_q <= snoozed_d;
        end
    end

    // Counter holds the remaining ticks; the tick that lands on 1 ends the interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        if (wr) begin
            slot_d  = wr_time;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sec_tick && now == slot_q) begin
                        state_d = RINGING;
                        cnt_d   = RING_CNT;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_d = IDLE;
                    end else if (snooze) begin
                        state_d = SNOOZED;
                        cnt_d   = SNOOZE_CNT;
                    end else if (sec_tick) begin
                        if (cnt_q <= 16'd1) state_d = IDLE;
                        else                cnt_d   = cnt_q - 16'd1;
                    end
                end
                SNOOZED: begin
                    if (dismiss) begin
                        state_d = IDLE;
                    end else if (sec_tick) begin
                        if (cnt_q <= 16'd1) begin
                            state_d = RINGING;
                            cnt_d   = RING_CNT;
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ring_d    = (state_d == RINGING);
        snoozed_d = (state_d == SNOOZED);
    end

    assign ring      = ring_q;
    assign snoozed   = snoozed_q;
    assign ring_next = ring_d;

endmodule

// File: rtl/alarm_timekeeper.sv
// 24-hour BCD timekeeper with prescaler, validated time/alarm loads and
// NUM_ALARMS independent alarm channels.
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned NUM_ALARMS     = 4,
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned RING_TIMEOUT_S = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_time_valid,
    input  logic [23:0]           set_time,
    input  logic                  alarm_wr,
    input  logic [2:0]            alarm_idx,
    input  logic [23:0]           alarm_time,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [23:0]           time_bcd,
    output logic                  sec_tick,
    output logic [NUM_ALARMS-1:0] ring,
    output logic                  ring_any,
    output logic [NUM_ALARMS-1:0] snoozed,
    output logic                  set_err
);

    localparam int unsigned    PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0]         presc_q, presc_d;
    bcd_time_t             time_q, time_d;
    logic                  sec_tick_q, sec_tick_d;
    logic                  set_err_q, set_err_d;
    logic                  ring_any_q, ring_any_d;
    logic                  tick, set_ok, alarm_ok, alarm_in_range;
    logic [NUM_ALARMS-1:0] wr_sel;
    logic [NUM_ALARMS-1:0] ring_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
            ring_any_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            time_q     <= time_d;
            sec_tick_q <= sec_tick_d;
            set_err_q  <= set_err_d;
            ring_any_q <= ring_any_d;
        end
    end

    // A valid load wins over a coincident tick; an invalid one leaves counting untouched.
    always_comb begin
        tick           = (presc_q == PRESC_MAX);
        set_ok         = bcd_time_valid(bcd_time_t'(set_time));
        alarm_ok       = bcd_time_valid(bcd_time_t'(alarm_time));
        alarm_in_range = (32'(alarm_idx) < NUM_ALARMS);
        presc_d        = tick ? '0 : presc_q + PW'(1);
        time_d         = time_q;
        sec_tick_d     = 1'b0;
        if (set_time_valid && set_ok) begin
            time_d  = bcd_time_t'(set_time);
            presc_d = '0;
        end else if (tick) begin
            time_d     = bcd_inc(time_q);
            sec_tick_d = 1'b1;
        end
        set_err_d = (set_time_valid && !set_ok) ||
                    (alarm_wr && alarm_in_range && !alarm_ok);
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            wr_sel[i] = alarm_wr && alarm_ok && (32'(alarm_idx) == i);
        end
        ring_any_d = |ring_next;
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
        alarm_channel #(
            .SNOOZE_S       (SNOOZE_S),
            .RING_TIMEOUT_S (RING_TIMEOUT_S)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr        (wr_sel[i]),
            .wr_time   (bcd_time_t'(alarm_time)),
            .en        (alarm_en[i]),
            .sec_tick  (sec_tick_q),
            .now       (time_q),
            .snooze    (snooze),
            .dismiss   (dismiss),
            .ring      (ring[i]),
            .snoozed   (snoozed[i]),
            .ring_next (ring_next[i])
        );
    end

    assign time_bcd = time_q;
    assign sec_tick = sec_tick_q;
    assign ring_any = ring_any_q;
    assign set_err  = set_err_q;

endmodule
